// File: rtl/wrr_arbiter_if.sv
// ============================================================================
// Module      : wrr_arbiter_if
// Description : Request/grant bundle between requesters and wrr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wrr_arbiter_if #(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req_i;
    logic [N-1:0]    last_i;
    logic [N*WW-1:0] weight_i;
    logic            ready_i;
    logic [N-1:0]    gnt_o;
    logic            gnt_valid_o;
    logic [IDW-1:0]  gnt_id_o;

    modport master (
        output req_i, last_i, weight_i, ready_i,
        input  gnt_o, gnt_valid_o, gnt_id_o
    );

    modport slave (
        input  req_i, last_i, weight_i, ready_i,
        output gnt_o, gnt_valid_o, gnt_id_o
    );
endinterface

`default_nettype wire

// File: rtl/wrr_arbiter.sv
// ============================================================================
// Module      : wrr_arbiter
// Description : Weighted round-robin arbiter; owner keeps the grant for
//               weight-many bursts, a burst ending on a last beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    wrr_arbiter_if.slave  bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [WW-1:0]  credit_q, credit_d;
    logic           in_burst_q, in_burst_d;

    logic [IDW-1:0] winner;
    logic           found;
    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand;
    logic [WW-1:0]  win_weight;
    logic           owner_req;
    logic           owner_last;

    // Search ptr+1 .. ptr with wrap; the sum is one bit wider so the modulo
    // reduces to a single conditional subtract for any N.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 1; i <= N; i++) begin
            cand_sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand_sum >= (IDW+1)'(N)) begin
                cand_sum = cand_sum - (IDW+1)'(N);
            end
            cand = cand_sum[IDW-1:0];
            if (!found && bus.req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_weight = '0;
        for (int k = 0; k < N; k++) begin
            if (winner == IDW'(k)) begin
                win_weight = bus.weight_i[k*WW +: WW];
            end
        end
    end

    assign owner_req  = bus.req_i[id_q];
    assign owner_last = bus.last_i[id_q];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        in_burst_d = in_burst_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = BUSY;
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                    id_d          = winner;
                    ptr_d         = winner;
                    credit_d      = (win_weight == '0) ? WW'(1) : win_weight;
                    in_burst_d    = 1'b0;
                end
            end
            BUSY: begin
                // ready_i low freezes everything, including a would-be release.
                if (bus.ready_i) begin
                    if (owner_req) begin
                        if (!owner_last) begin
                            in_burst_d = 1'b1;
                        end else if (credit_q > WW'(1)) begin
                            credit_d   = credit_q - WW'(1);
                            in_burst_d = 1'b0;
                        end else begin
                            state_d    = IDLE;
                            gnt_d      = '0;
                            id_d       = '0;
                            credit_d   = '0;
                            in_burst_d = 1'b0;
                        end
                    end else if (!in_burst_q) begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        id_d       = '0;
                        credit_d   = '0;
                        in_burst_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                id_d       = '0;
                credit_d   = '0;
                in_burst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            id_q       <= '0;
            ptr_q      <= IDW'(N - 1);
            credit_q   <= '0;
            in_burst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
            in_burst_q <= in_burst_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = |gnt_q;
    assign bus.gnt_id_o    = id_q;

endmodule

`default_nettype wire

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (legal 2..16).
REQ-002 SHALL have parameter WW, default 4, per-requester weight width in bits (legal 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_i  input  N  request per requester.
REQ-006 SHALL have port last_i  input  N  final beat of requester's current burst.
REQ-007 SHALL have port weight_i  input  N*WW  packed weights; requester k at bits [k*WW +: WW].
REQ-008 SHALL have port ready_i  input  1  downstream accepts a beat this cycle.
REQ-009 SHALL have port gnt_o  output  N  registered one-hot grant; all-zero when no owner.
REQ-010 SHALL have port gnt_valid_o  output  1  equals OR of gnt_o.
REQ-011 SHALL have port gnt_id_o  output  max(1,clog2(N))  binary index of owner; 0 when gnt_valid_o=0.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and BUSY (owner held in gnt_o).
REQ-013 IDLE: if req_i!=0, SHALL select winner by round-robin, load state BUSY, gnt_o=onehot(winner) from next cycle (1-cycle req-to-grant latency).
REQ-014 Round-robin SHALL start search at index ptr+1 wrapping through N-1 to 0 to ptr; first requesting index wins.
REQ-015 ptr SHALL update to winner index at each grant load.
REQ-016 At grant load, credit counter (WW bits) SHALL load weight_i[winner]; weight 0 SHALL load 1.
REQ-017 weight_i SHALL be sampled only at grant load; changes during BUSY have no effect on current ownership.
REQ-018 Beat transfer SHALL be defined as BUSY & ready_i & req_i[owner].
REQ-019 On transfer with last_i[owner]=0: in_burst flag SHALL set; credit unchanged; remain BUSY.
REQ-020 On transfer with last_i[owner]=1 and credit>1: credit SHALL decrement by 1, in_burst clears, remain BUSY.
REQ-021 On transfer with last_i[owner]=1 and credit==1: SHALL release -> IDLE, gnt_o=0 next cycle.
REQ-022 In BUSY with req_i[owner]=0 and in_burst=0: SHALL release -> IDLE next cycle (owner gave up remaining credit).
REQ-023 In BUSY with req_i[owner]=0 and in_burst=1: SHALL hold grant (stall); no release, credit unchanged.
REQ-024 ready_i=0 SHALL freeze credit, in_burst and ownership.
REQ-025 Requests from non-owners SHALL never preempt an owner.
REQ-026 Every release SHALL produce exactly one IDLE cycle (gnt_o=0) before the next grant.
REQ-027 last_i and req_i of non-owners SHALL be ignored; last_i without transfer SHALL be ignored.

Reset
REQ-028 reset_n=0 SHALL immediately (asynchronously) force: state IDLE, gnt_o=0, gnt_valid_o=0, gnt_id_o=0, credit=0, in_burst=0, ptr=N-1.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; after deassertion index 0 has highest priority.

Verification (N=4, WW=4)
REQ-030 Reset, req_i=1111, all weights 1, last_i=1111, ready_i=1 -> gnt_o sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-031 weight0=3, weight1=1, req_i=0011, last_i=1111, ready_i=1 -> gnt_o 0001 for 3 consecutive cycles, 0000, then 0010 for 1 cycle, 0000, then 0001 again.
REQ-032 Owner 0 with weight 1, last_i[0]=1 only on 4th beat, req_i=1111 throughout -> gnt_o=0001 held 4 beats, then 0000, then 0010.
REQ-033 Owner 2 granted, ready_i=0 for 5 cycles -> gnt_o=0100, gnt_id_o=2 stable; credit unchanged; transfer resumes when ready_i=1.
REQ-034 weight3=0, req_i=1000, last_i=1000 -> single beat granted (gnt_o=1000 one cycle), then 0000.
REQ-035 Owner 1 with weight 4 mid-burst (in_burst=1), assert reset_n=0 -> gnt_o=0000 same cycle; release reset with req_i=1111 -> first grant 0001.
